// File: rtl/fpu_add_seq.sv
// Issue/collect sequencer in front of a fixed-latency, non-stalling FPU add unit.
// Build macro FPU_SEQ_BYPASS_EN lets an exiting result skip an empty response FIFO.
module fpu_add_seq #(
  parameter int LAT        = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [63:0]      req_rn,
  input  logic [63:0]      req_rm,
  input  logic [7:0]       req_rmode,
  input  logic [TAG_W-1:0] req_tag,
  output logic [63:0]      add_valrn,
  output logic [63:0]      add_valrm,
  output logic [3:0]       add_exop,
  output logic [7:0]       add_rmode,
  output logic             add_exhold,
  input  logic [63:0]      add_valro,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_value,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int SLOTS = LAT + 1;
  localparam int INF_W = $clog2(SLOTS + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SUM_W = INF_W + CNT_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} seqState;

  seqState          stateReg, stateNext;
  logic [7:0]       curRmodeReg, curRmodeNext;
  logic             liveReg;

  logic [3:0]       exOpReg;
  logic [63:0]      valRnReg, valRmReg;

  logic [SLOTS-1:0] slotValid, slotIllegal;
  logic [TAG_W-1:0] slotTag [SLOTS];
  logic [INF_W-1:0] inflight;

  logic [63:0]      fifoValue [FIFO_DEPTH];
  logic [TAG_W-1:0] fifoTag [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtrReg, rdPtrReg;
  logic [CNT_W-1:0] countReg;

  logic             reqIllegal, creditOk, modeOk, readyInt, accept;
  logic             exitValid;
  logic [TAG_W-1:0] exitTag;
  logic [63:0]      exitValue;
  logic             fifoEmpty, bypassTake, push, pop;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign reqIllegal = (req_op[2:0] == 3'd0) || (req_op[2:0] > 3'd4);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < SLOTS; i++) begin
      inflight = inflight + INF_W'(slotValid[i]);
    end
  end

  // Credits cover both in-flight slots and buffered results, so the FIFO can never overflow.
  assign creditOk  = (SUM_W'(inflight) + SUM_W'(countReg)) < SUM_W'(FIFO_DEPTH);
  assign modeOk    = (stateReg == IDLE) || (req_rmode == curRmodeReg);
  assign readyInt  = liveReg && (stateReg != DRAIN) && creditOk && modeOk;
  assign accept    = req_valid && readyInt;
  assign req_ready = readyInt;

  always_comb begin
    stateNext    = stateReg;
    curRmodeNext = curRmodeReg;
    case (stateReg)
      IDLE: begin
        if (accept) begin
          stateNext    = RUN;
          curRmodeNext = req_rmode;
        end
      end
      RUN: begin
        if (accept) begin
          stateNext = RUN;
        end else if (req_valid && (req_rmode != curRmodeReg)) begin
          stateNext = DRAIN;
        end else if (inflight == '0) begin
          stateNext = IDLE;
        end
      end
      DRAIN: begin
        if (inflight == '0) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateReg    <= IDLE;
      curRmodeReg <= 8'd0;
      liveReg     <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      curRmodeReg <= curRmodeNext;
      liveReg     <= 1'b1;
    end
  end

  // Operands hold between ops; only the opcode returns to zero when nothing is issued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exOpReg  <= 4'd0;
      valRnReg <= 64'd0;
      valRmReg <= 64'd0;
    end else if (accept) begin
      exOpReg  <= reqIllegal ? 4'd0 : req_op;
      valRnReg <= req_rn;
      valRmReg <= req_rm;
    end else begin
      exOpReg  <= 4'd0;
    end
  end

  assign add_exop   = exOpReg;
  assign add_valrn  = valRnReg;
  assign add_valrm  = valRmReg;
  assign add_rmode  = curRmodeReg;
  assign add_exhold = 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slotValid   <= '0;
      slotIllegal <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        slotTag[i] <= '0;
      end
    end else begin
      slotValid   <= {slotValid[SLOTS-2:0], accept};
      slotIllegal <= {slotIllegal[SLOTS-2:0], accept && reqIllegal};
      slotTag[0]  <= req_tag;
      for (int i = 1; i < SLOTS; i++) begin
        slotTag[i] <= slotTag[i-1];
      end
    end
  end

  assign exitValid = slotValid[SLOTS-1];
  assign exitTag   = slotTag[SLOTS-1];
  assign exitValue = slotIllegal[SLOTS-1] ? 64'd0 : add_valro;
  assign fifoEmpty = (countReg == '0);

`ifdef FPU_SEQ_BYPASS_EN
  assign bypassTake = exitValid && fifoEmpty && rsp_ready;
`else
  assign bypassTake = 1'b0;
`endif

  assign push = exitValid && !bypassTake;
  assign pop  = !fifoEmpty && rsp_ready;

  always_ff @(posedge clock) begin
    if (push) begin
      fifoValue[wrPtrReg] <= exitValue;
      fifoTag[wrPtrReg]   <= exitTag;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (push) wrPtrReg <= ptrInc(wrPtrReg);
      if (pop)  rdPtrReg <= ptrInc(rdPtrReg);
      case ({push, pop})
        2'b10:   countReg <= countReg + CNT_W'(1);
        2'b01:   countReg <= countReg - CNT_W'(1);
        default: countReg <= countReg;
      endcase
    end
  end

  always_comb begin
    rsp_valid = 1'b0;
    rsp_value = 64'd0;
    rsp_tag   = '0;
    if (!fifoEmpty) begin
      rsp_valid = 1'b1;
      rsp_value = fifoValue[rdPtrReg];
      rsp_tag   = fifoTag[rdPtrReg];
    end else if (bypassTake) begin
      rsp_valid = 1'b1;
      rsp_value = exitValue;
      rsp_tag   = exitTag;
    end
  end

  assign busy = (inflight != '0) || !fifoEmpty;

endmodule
